// File: rtl/placement_pkg.sv
// Types and constants shared by the placer and the grid readback reader.
package placement_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  // Grid word that marks an unoccupied cell.
  localparam logic signed [DATA_W-1:0] EMPTY = -1;

  typedef enum logic [3:0] {
    IDLE,
    G_RD,
    G_WAIT,
    G_CHK,
    P_RD,
    P_WAIT,
    P_CMP,
    EMIT,
    NEXT,
    FIN
  } rb_state_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] node;
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] y;
    logic                     ok;
  } rec_t;

endpackage

// File: rtl/rb_out_reg.sv
// Output holding register: captures one record and keeps it stable until the sink accepts it.
module rb_out_reg
  import placement_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  rec_t rec_in,
  input  logic ready,
  output logic valid,
  output rec_t rec
);

  logic valid_reg;
  rec_t rec_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      rec_reg   <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      rec_reg   <= rec_in;
    end else if (valid_reg && ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign rec   = rec_reg;

endmodule

// File: rtl/grid_readback.sv
// Raster-order scan of the placement grid, streaming one record per occupied cell.
// Define GRIDRB_POSCHECK_EN to read node positions back and flag cells whose stored position disagrees.
module grid_readback
  import placement_pkg::*;
#(
  parameter int N      = 7,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     grid_re,
  output logic [ADDR_W-1:0]        grid_addr,
  input  logic signed [DATA_W-1:0] grid_dout,
  output logic                     pos_re,
  output logic [ADDR_W-1:0]        pos_addr,
  input  logic signed [DATA_W-1:0] posx_dout,
  input  logic signed [DATA_W-1:0] posy_dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_node,
  output logic signed [DATA_W-1:0] out_x,
  output logic signed [DATA_W-1:0] out_y,
  output logic                     out_ok,
  output logic [ADDR_W-1:0]        occ_cnt,
  output logic [ADDR_W-1:0]        err_cnt
);

  localparam logic [ADDR_W-1:0]        ADDR_LAST = ADDR_W'(N*N-1);
  localparam logic signed [DATA_W-1:0] Y_LAST    = DATA_W'(N-1);
  localparam logic [7:0]               LAT_LAST  = 8'(RD_LAT-1);

  rb_state_t                state_reg, state_next;
  logic [ADDR_W-1:0]        addr_reg, addr_next;
  logic [ADDR_W-1:0]        occ_reg, occ_next;
  logic signed [DATA_W-1:0] x_reg, x_next;
  logic signed [DATA_W-1:0] y_reg, y_next;
  logic [7:0]               wait_reg, wait_next;
  logic                     load;
  rec_t                     rec_in;
  rec_t                     rec_out;

`ifdef GRIDRB_POSCHECK_EN
  logic signed [DATA_W-1:0] node_reg, node_next;
  logic [ADDR_W-1:0]        err_reg, err_next;
  logic                     pos_ok;

  assign pos_ok = (posx_dout == x_reg) && (posy_dout == y_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      node_reg <= '0;
      err_reg  <= '0;
    end else begin
      node_reg <= node_next;
      err_reg  <= err_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      occ_reg   <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      occ_reg   <= occ_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      wait_reg  <= wait_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    occ_next   = occ_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    wait_next  = wait_reg;
    load       = 1'b0;
    rec_in     = '0;
`ifdef GRIDRB_POSCHECK_EN
    node_next  = node_reg;
    err_next   = err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          addr_next  = '0;
          x_next     = '0;
          y_next     = '0;
          occ_next   = '0;
`ifdef GRIDRB_POSCHECK_EN
          err_next   = '0;
`endif
          state_next = G_RD;
        end
      end
      G_RD: begin
        wait_next  = '0;
        state_next = G_WAIT;
      end
      G_WAIT: begin
        if (wait_reg == LAT_LAST) state_next = G_CHK;
        else wait_next = wait_reg + 8'd1;
      end
      G_CHK: begin
        if (grid_dout == EMPTY) begin
          state_next = NEXT;
        end else begin
          occ_next = occ_reg + ADDR_W'(1);
`ifdef GRIDRB_POSCHECK_EN
          node_next  = grid_dout;
          state_next = P_RD;
`else
          load        = 1'b1;
          rec_in.node = grid_dout;
          rec_in.x    = x_reg;
          rec_in.y    = y_reg;
          rec_in.ok   = 1'b1;
          state_next  = EMIT;
`endif
        end
      end
`ifdef GRIDRB_POSCHECK_EN
      P_RD: begin
        wait_next  = '0;
        state_next = P_WAIT;
      end
      P_WAIT: begin
        if (wait_reg == LAT_LAST) state_next = P_CMP;
        else wait_next = wait_reg + 8'd1;
      end
      P_CMP: begin
        load        = 1'b1;
        rec_in.node = node_reg;
        rec_in.x    = x_reg;
        rec_in.y    = y_reg;
        rec_in.ok   = pos_ok;
        if (!pos_ok) err_next = err_reg + ADDR_W'(1);
        state_next  = EMIT;
      end
`endif
      EMIT: begin
        if (out_valid && out_ready) state_next = NEXT;
      end
      NEXT: begin
        if (addr_reg == ADDR_LAST) begin
          state_next = FIN;
        end else begin
          addr_next = addr_reg + ADDR_W'(1);
          // Row/column tracked as counters so the address never needs dividing.
          if (y_reg == Y_LAST) begin
            y_next = '0;
            x_next = x_reg + DATA_W'(1);
          end else begin
            y_next = y_reg + DATA_W'(1);
          end
          state_next = G_RD;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  rb_out_reg u_out_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .rec_in (rec_in),
    .ready  (out_ready),
    .valid  (out_valid),
    .rec    (rec_out)
  );

  assign busy      = (state_reg != IDLE) && (state_reg != FIN);
  assign done      = (state_reg == FIN);
  assign grid_re   = (state_reg == G_RD);
  assign grid_addr = addr_reg;
  assign occ_cnt   = occ_reg;
  assign out_node  = rec_out.node;
  assign out_x     = rec_out.x;
  assign out_y     = rec_out.y;

`ifdef GRIDRB_POSCHECK_EN
  assign pos_re   = (state_reg == P_RD);
  assign pos_addr = ADDR_W'(node_reg);
  assign out_ok   = rec_out.ok;
  assign err_cnt  = err_reg;
`else
  logic unused_inputs;
  assign unused_inputs = ^{posx_dout, posy_dout, rec_out.ok};
  assign pos_re   = 1'b0;
  assign pos_addr = '0;
  assign out_ok   = 1'b1;
  assign err_cnt  = '0;
`endif

endmodule

// File: doc/grid_readback.md
Name: grid_readback

Overview:
- Reader for the placement grid RAM and node-position RAMs that the placer fills.
- After placement finishes, it scans every grid cell in raster order and skips empty cells.
- For each occupied cell it streams (node, x, y, ok) over a valid/ready handshake and counts occupied cells.
- Sits between the placer's memories and the result dump/host interface.

Parameters:
N, 7, grid side; the grid has N*N cells, cell address = x*N+y
DATA_W, 32, memory word width; signed
ADDR_W, 32, memory address width
EMPTY, -1, grid word that marks an unoccupied cell
RD_LAT, 1, cycles from a read-enable-high cycle to valid dout (min 1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; starts a scan when idle
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last cell is processed
grid_re  out  1  grid read enable
grid_addr  out  ADDR_W  grid read address
grid_dout  in  DATA_W  grid read data (node id or EMPTY)
pos_re  out  1  shared read enable for pos_X and pos_Y
pos_addr  out  ADDR_W  node id
posx_dout  in  DATA_W  stored x of the node
posy_dout  in  DATA_W  stored y of the node
out_valid  out  1  output record valid
out_ready  in  1  sink ready
out_node  out  DATA_W  node id
out_x  out  DATA_W  cell row
out_y  out  DATA_W  cell column
out_ok  out  1  stored position equals (out_x, out_y)
occ_cnt  out  ADDR_W  occupied cells found in the current/last scan
err_cnt  out  ADDR_W  records emitted with out_ok=0

Behaviour:
- Reset: clk is single; reset is asynchronous, active-low. All outputs go to 0 and the FSM goes to IDLE. Reset mid-scan aborts the scan immediately, with no done pulse.
- FSM states: IDLE, G_RD, G_WAIT, G_CHK, P_RD, P_WAIT, P_CMP, EMIT, NEXT, FIN.
- IDLE: start=1 loads x=0, y=0, addr=0, occ_cnt=0, err_cnt=0, then goes to G_RD. start is ignored in every other state.
- G_RD: grid_re=1 for exactly one cycle with grid_addr=addr. G_WAIT holds for RD_LAT cycles.
- G_CHK: registers grid_dout.
  - If EMPTY: go to NEXT.
  - Otherwise: occ_cnt+1, go to P_RD.
- P_RD: pos_re=1 for one cycle with pos_addr=node. P_WAIT holds for RD_LAT cycles.
- P_CMP: ok = (posx_dout==x && posy_dout==y); err_cnt+1 if !ok; go to EMIT.
- EMIT: out_valid=1. out_node/x/y/ok are stable while valid and !ready. Transfer happens when valid&&ready, then go to NEXT. Back-to-back records are not possible: at least one cycle of out_valid=0 separates records.
- NEXT:
  - If addr==N*N-1: go to FIN.
  - Else: addr+1; y+1, with wrap y=N-1 -> 0 and x+1. No divider; x and y are counters. Go to G_RD.
- FIN: done=1 for one cycle, busy falls in the same cycle, return to IDLE. occ_cnt and err_cnt hold until the next start.
- Read enables are never high outside G_RD/P_RD. Addresses hold their last value otherwise.
- A node id outside 0..2^ADDR_W-1 is passed through unchecked. All comparisons are signed at DATA_W.
- Latency per empty cell: 3+RD_LAT cycles. Per occupied cell: 6+2*RD_LAT cycles plus sink stall.

Optional Feature:
- Macro GRIDRB_POSCHECK_EN.
- Defined: behaviour as above.
- Undefined:
  - P_RD, P_WAIT and P_CMP are removed; G_CHK goes straight to EMIT.
  - pos_re is tied 0, pos_addr is tied 0, out_ok is tied 1, err_cnt is tied 0.
  - posx_dout and posy_dout are unused.

Decomposition:
- Shared package placement_pkg:
  - FSM state enum.
  - EMPTY constant.
  - Record struct {node, x, y, ok}.
  - DATA_W and ADDR_W defaults, reused by the placer.
- One sub-module: rb_out_reg, the output holding register with the valid/ready hold logic.

Test Plan:
- Empty 7x7 grid, start -> 49 grid reads, no out_valid, done 1 cycle, occ_cnt=0, err_cnt=0.
- Grid[3*7+4]=5, posX[5]=3, posY[5]=4, out_ready=1 -> one record (5,3,4,ok=1), occ_cnt=1.
- Same as above but posY[5]=2 -> out_ok=0, err_cnt=1. Without GRIDRB_POSCHECK_EN: ok=1, err_cnt=0, pos_re never high.
- Cells 0 and 48 occupied (nodes 0 and 9), out_ready low for 10 cycles on the first record -> record held stable for 10 cycles; both records delivered in order; done after the second.
- Reset driven low mid-EMIT -> out_valid, busy and counters go to 0 asynchronously. A following start performs a full clean scan.
- start pulsed while busy -> ignored; exactly one done per accepted start.
